// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter and its pick logic.
package imem_pkg;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_FETCH,
      OWN_LOAD
   } owner_t;

   localparam int WORD_ADR_W   = 30;
   localparam int DEF_MEM_SIZE = 1024;

   // Bit positions inside the one-hot grant vector.
   localparam int GNT_F = 0;
   localparam int GNT_L = 1;

   function automatic logic word_in_range(input logic [WORD_ADR_W-1:0] word_adr,
                                          input int mem_size);
      return 32'(word_adr) < 32'(mem_size);
   endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory arbiter.
interface imem_arbiter_if;

   logic        f_req;
   logic [31:0] f_adr;
   logic        f_gnt;
   logic        f_rvalid;
   logic [31:0] f_rdata;
   logic        f_err;

   logic        l_req;
   logic        l_we;
   logic        l_lock;
   logic [31:0] l_adr;
   logic [31:0] l_wdata;
   logic        l_gnt;
   logic        l_rvalid;
   logic [31:0] l_rdata;
   logic        l_err;

   logic [31:0] mem_adr;
   logic        mem_load;
   logic [31:0] mem_in;
   logic [31:0] mem_out;
   logic        mem_done;

   modport slave (
      input  f_req, f_adr, l_req, l_we, l_lock, l_adr, l_wdata, mem_out, mem_done,
      output f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata, l_err,
             mem_adr, mem_load, mem_in
   );

   modport master (
      output f_req, f_adr, l_req, l_we, l_lock, l_adr, l_wdata, mem_out, mem_done,
      input  f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata, l_err,
             mem_adr, mem_load, mem_in
   );

endinterface

// File: rtl/imem_arb_pick.sv
// Combinational winner selection: round-robin with a bounded loader burst lock.
module imem_arb_pick
   import imem_pkg::*;
#(
   parameter int MAX_BURST = 8
) (
   input  logic       f_req,
   input  logic       l_req,
   input  logic       l_lock,
   input  owner_t     last,
   input  logic [7:0] burst_cnt,
   input  logic       mem_done,
   output logic [1:0] gnt
);

   // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      gnt = '0;
      if (mem_done) begin
         if (f_req && !l_req) begin
            gnt[GNT_F] = 1'b1;
         end else if (l_req && !f_req) begin
            gnt[GNT_L] = 1'b1;
         end else if (f_req && l_req) begin
            if (l_lock && last == OWN_LOAD && burst_cnt < 8'(MAX_BURST)) begin
               gnt[GNT_L] = 1'b1;
            end else if (last == OWN_LOAD) begin
               gnt[GNT_F] = 1'b1;
            end else begin
               gnt[GNT_L] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one single-ported instruction memory between fetch (read) and loader (read/write).
module imem_arbiter
   import imem_pkg::*;
#(
   parameter int MEM_SIZE  = DEF_MEM_SIZE,
   parameter int MAX_BURST = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   imem_arbiter_if.slave bus
);

   owner_t     last_q, last_d;
   logic [7:0] burst_cnt_q, burst_cnt_d;
   owner_t     owner_q, owner_d;
   logic       is_wr_q, is_wr_d;
   logic       oor_q, oor_d;

   logic [1:0] pick_gnt;
   logic       f_gnt, l_gnt;
   logic       f_oor, l_oor;

   imem_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
      .f_req     (bus.f_req),
      .l_req     (bus.l_req),
      .l_lock    (bus.l_lock),
      .last      (last_q),
      .burst_cnt (burst_cnt_q),
      .mem_done  (bus.mem_done),
      .gnt       (pick_gnt)
   );

   // Grants are held off combinationally for the whole reset window.
   assign f_gnt     = pick_gnt[GNT_F] & rst_n;
   assign l_gnt     = pick_gnt[GNT_L] & rst_n;
   assign bus.f_gnt = f_gnt;
   assign bus.l_gnt = l_gnt;

   assign f_oor = !word_in_range(bus.f_adr[31:2], MEM_SIZE);
   assign l_oor = !word_in_range(bus.l_adr[31:2], MEM_SIZE);

   always_comb begin
      last_d       = last_q;
      burst_cnt_d  = burst_cnt_q;
      owner_d      = OWN_NONE;
      is_wr_d      = 1'b0;
      oor_d        = 1'b0;
      bus.mem_adr  = '0;
      bus.mem_load = 1'b0;
      bus.mem_in   = '0;

      if (f_gnt) begin
         last_d      = OWN_FETCH;
         owner_d     = OWN_FETCH;
         oor_d       = f_oor;
         bus.mem_adr = bus.f_adr;
      end else if (l_gnt) begin
         last_d       = OWN_LOAD;
         owner_d      = OWN_LOAD;
         is_wr_d      = bus.l_we;
         oor_d        = l_oor;
         bus.mem_adr  = bus.l_adr;
         bus.mem_load = bus.l_we & ~l_oor;
         bus.mem_in   = bus.l_wdata;
      end

      if (!bus.l_lock || f_gnt) begin
         burst_cnt_d = '0;
      end else if (l_gnt && bus.f_req && burst_cnt_q < 8'(MAX_BURST)) begin
         burst_cnt_d = burst_cnt_q + 8'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q      <= OWN_LOAD;
         burst_cnt_q <= '0;
         owner_q     <= OWN_NONE;
         is_wr_q     <= 1'b0;
         oor_q       <= 1'b0;
      end else begin
         last_q      <= last_d;
         burst_cnt_q <= burst_cnt_d;
         owner_q     <= owner_d;
         is_wr_q     <= is_wr_d;
         oor_q       <= oor_d;
      end
   end

   // Response stage: mem_out is already registered inside the memory, so it is steered straight through.
   always_comb begin
      bus.f_rvalid = (owner_q == OWN_FETCH);
      bus.f_err    = (owner_q == OWN_FETCH) && oor_q;
      bus.f_rdata  = (owner_q == OWN_FETCH && !oor_q) ? bus.mem_out : '0;
      bus.l_rvalid = (owner_q == OWN_LOAD);
      bus.l_err    = (owner_q == OWN_LOAD) && oor_q;
      bus.l_rdata  = (owner_q == OWN_LOAD && !oor_q && !is_wr_q) ? bus.mem_out : '0;
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_imem_arbiter;

   localparam int MEM_SIZE  = 1024;
   localparam int MAX_BURST = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic fill;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [31:0] mem [0:MEM_SIZE-1];

   imem_arbiter_if bus ();

   imem_arbiter #(.MEM_SIZE(MEM_SIZE), .MAX_BURST(MAX_BURST)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] img(input int i);
      return {16'hC0DE, 16'(i)};
   endfunction

   // Memory with a registered read port; preloaded while fill is high.
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < MEM_SIZE; i++) mem[i] <= img(i);
      end else if (bus.mem_load) begin
         mem[bus.mem_adr[11:2]] <= bus.mem_in;
      end
      bus.mem_out <= mem[bus.mem_adr[11:2]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_str(input string name, input string act, input string exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %s expected %s", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic string gnt_char();
      if (bus.f_gnt) return "F";
      if (bus.l_gnt) return "L";
      return "-";
   endfunction

   function automatic logic [31:0] rand_adr();
      logic [31:0] w;
      case ($urandom_range(0, 15))
         0:       w = $urandom_range(MEM_SIZE, 4095);
         1, 2:    w = $urandom_range(0, MEM_SIZE - 1);
         default: w = $urandom_range(0, 31);
      endcase
      return (w << 2) | 32'($urandom_range(0, 3));
   endfunction

   function automatic logic is_oor(input logic [31:0] adr);
      return {2'b00, adr[31:2]} >= 32'(MEM_SIZE);
   endfunction

   task automatic do_reset();
      rst_n      = 1'b0;
      bus.f_req  = 1'b0;
      bus.l_req  = 1'b0;
      bus.l_we   = 1'b0;
      bus.l_lock = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Behavioural model: predicts grants, memory drive and responses every cycle.
   initial begin : model
      logic        last_was_l;
      int          burst;
      int          p_own;
      logic        p_oor;
      logic [31:0] p_data;
      logic [31:0] ref_mem [0:MEM_SIZE-1];
      logic        fw, lw, l_oor;
      logic [31:0] e_adr;

      for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = img(i);
      last_was_l = 1'b1;
      burst      = 0;
      p_own      = 0;
      p_oor      = 1'b0;
      p_data     = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("rst_f_gnt", bus.f_gnt, 0);
            check("rst_l_gnt", bus.l_gnt, 0);
            check("rst_f_rvalid", bus.f_rvalid, 0);
            check("rst_l_rvalid", bus.l_rvalid, 0);
            check("rst_mem_load", bus.mem_load, 0);
            last_was_l = 1'b1;
            burst      = 0;
            p_own      = 0;
            continue;
         end

         fw = 1'b0;
         lw = 1'b0;
         if (bus.mem_done) begin
            if (bus.f_req && bus.l_req) begin
               if (last_was_l && bus.l_lock && burst < MAX_BURST) lw = 1'b1;
               else begin
                  fw = last_was_l;
                  lw = !last_was_l;
               end
            end else begin
               fw = bus.f_req;
               lw = bus.l_req;
            end
         end
         check("f_gnt", bus.f_gnt, fw);
         check("l_gnt", bus.l_gnt, lw);

         check("f_rvalid", bus.f_rvalid, p_own == 1);
         check("f_rdata", bus.f_rdata, (p_own == 1) ? p_data : 32'h0);
         check("f_err", bus.f_err, p_own == 1 && p_oor);
         check("l_rvalid", bus.l_rvalid, p_own == 2);
         check("l_rdata", bus.l_rdata, (p_own == 2) ? p_data : 32'h0);
         check("l_err", bus.l_err, p_own == 2 && p_oor);

         l_oor = is_oor(bus.l_adr);
         e_adr = fw ? bus.f_adr : (lw ? bus.l_adr : 32'h0);
         check("mem_adr", bus.mem_adr, e_adr);
         check("mem_load", bus.mem_load, lw && bus.l_we && !l_oor);
         if (!fw) check("mem_in", bus.mem_in, lw ? bus.l_wdata : 32'h0);

         if (fw) begin
            p_own  = 1;
            p_oor  = is_oor(bus.f_adr);
            p_data = p_oor ? 32'h0 : ref_mem[bus.f_adr[11:2]];
         end else if (lw) begin
            p_own  = 2;
            p_oor  = l_oor;
            p_data = (l_oor || bus.l_we) ? 32'h0 : ref_mem[bus.l_adr[11:2]];
            if (bus.l_we && !l_oor) ref_mem[bus.l_adr[11:2]] = bus.l_wdata;
         end else begin
            p_own = 0;
         end
         if (fw) last_was_l = 1'b0;
         else if (lw) last_was_l = 1'b1;
         if (!bus.l_lock || fw) burst = 0;
         else if (lw && bus.f_req && burst < MAX_BURST) burst++;
      end
   end

   initial begin : watchdog
      #1_000_000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin : main
      string       s;
      logic        fh, lh;
      logic [31:0] seq_exp [3];
      seq_exp = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002};

      rst_n       = 1'b0;
      fill        = 1'b1;
      bus.f_req   = 1'b1;
      bus.f_adr   = '0;
      bus.l_req   = 1'b1;
      bus.l_we    = 1'b0;
      bus.l_lock  = 1'b0;
      bus.l_adr   = '0;
      bus.l_wdata = '0;
      bus.mem_done = 1'b1;

      // Requests during reset must not be granted.
      @(negedge clk);
      check("reset_f_gnt", bus.f_gnt, 0);
      check("reset_l_gnt", bus.l_gnt, 0);
      check("reset_mem_adr", bus.mem_adr, 0);
      check("reset_f_rdata", bus.f_rdata, 0);
      step();
      fill      = 1'b0;
      bus.f_req = 1'b0;
      bus.l_req = 1'b0;
      step();
      rst_n = 1'b1;

      // Fetch-only reads of words 0, 1, 2 back to back.
      bus.f_req = 1'b1;
      bus.f_adr = 32'h0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k < 3) check($sformatf("seq_f_gnt%0d", k), bus.f_gnt, 1);
         if (k > 0) begin
            check($sformatf("seq_f_rvalid%0d", k), bus.f_rvalid, 1);
            check($sformatf("seq_f_rdata%0d", k), bus.f_rdata, seq_exp[k-1]);
         end else begin
            check("seq_f_rvalid0", bus.f_rvalid, 0);
         end
         step();
         if (k < 2) bus.f_adr = 32'(4 * (k + 1));
         else bus.f_req = 1'b0;
      end

      // Continuous contention without lock alternates, fetch first after reset.
      do_reset();
      bus.f_req = 1'b1;
      bus.f_adr = 32'h20;
      bus.l_req = 1'b1;
      bus.l_adr = 32'h24;
      s = "";
      repeat (4) begin
         @(negedge clk);
         s = {s, gnt_char()};
         step();
      end
      check_str("alternate", s, "FLFL");

      // Locked loader burst against a waiting fetch.
      do_reset();
      bus.f_req   = 1'b1;
      bus.f_adr   = 32'h200;
      bus.l_req   = 1'b1;
      bus.l_we    = 1'b1;
      bus.l_lock  = 1'b1;
      bus.l_adr   = 32'h100;
      bus.l_wdata = 32'h1000_0100;
      s = "";
      repeat (17) begin
         @(negedge clk);
         lh = bus.l_gnt;
         s  = {s, gnt_char()};
         step();
         if (lh) begin
            bus.l_adr   = bus.l_adr + 32'd4;
            bus.l_wdata = 32'h1000_0000 | bus.l_adr;
         end
      end
      check_str("burst", s, "LLLLLLLLFLLLLLLLL");
      check("burst_end_adr", bus.l_adr, 32'h140);
      bus.f_req  = 1'b0;
      bus.l_req  = 1'b0;
      bus.l_lock = 1'b0;
      bus.l_we   = 1'b0;

      // Write then read-after-write on the next cycle.
      bus.l_req   = 1'b1;
      bus.l_we    = 1'b1;
      bus.l_adr   = 32'h40;
      bus.l_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("raw_l_gnt", bus.l_gnt, 1);
      step();
      bus.l_req = 1'b0;
      bus.l_we  = 1'b0;
      bus.f_req = 1'b1;
      bus.f_adr = 32'h40;
      @(negedge clk);
      check("raw_l_rvalid", bus.l_rvalid, 1);
      check("raw_l_rdata", bus.l_rdata, 0);
      check("raw_f_gnt", bus.f_gnt, 1);
      step();
      bus.f_req = 1'b0;
      @(negedge clk);
      check("raw_f_rvalid", bus.f_rvalid, 1);
      check("raw_f_rdata", bus.f_rdata, 32'hDEAD_BEEF);
      step();

      // Out-of-range write must not reach the array.
      bus.l_req   = 1'b1;
      bus.l_we    = 1'b1;
      bus.l_adr   = 32'h1000;
      bus.l_wdata = 32'h5555_AAAA;
      @(negedge clk);
      check("oor_l_gnt", bus.l_gnt, 1);
      check("oor_mem_load", bus.mem_load, 0);
      step();
      bus.l_req = 1'b0;
      bus.l_we  = 1'b0;
      bus.f_req = 1'b1;
      bus.f_adr = 32'h0;
      @(negedge clk);
      check("oor_l_rvalid", bus.l_rvalid, 1);
      check("oor_l_err", bus.l_err, 1);
      check("oor_l_rdata", bus.l_rdata, 0);
      step();
      bus.f_req = 1'b0;
      @(negedge clk);
      check("oor_word0", bus.f_rdata, 32'hC0DE_0000);
      check("oor_word0_err", bus.f_err, 0);
      step();

      // Memory busy blocks grants.
      bus.mem_done = 1'b0;
      bus.f_req    = 1'b1;
      bus.f_adr    = 32'h8;
      @(negedge clk);
      check("busy_f_gnt", bus.f_gnt, 0);
      step();
      bus.mem_done = 1'b1;
      @(negedge clk);
      check("unbusy_f_gnt", bus.f_gnt, 1);
      step();
      bus.f_req = 1'b0;

      // Reset in the cycle after a fetch grant drops the response.
      bus.f_req = 1'b1;
      bus.f_adr = 32'h10;
      @(negedge clk);
      check("mid_f_gnt", bus.f_gnt, 1);
      step();
      rst_n     = 1'b0;
      bus.f_req = 1'b0;
      @(negedge clk);
      check("mid_f_rvalid", bus.f_rvalid, 0);
      check("mid_f_rdata", bus.f_rdata, 0);
      check("mid_mem_adr", bus.mem_adr, 0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("post_f_rvalid", bus.f_rvalid, 0);
      step();
      bus.f_req = 1'b1;
      bus.l_req = 1'b1;
      bus.l_adr = 32'h4;
      @(negedge clk);
      check("post_first_f_gnt", bus.f_gnt, 1);
      check("post_first_l_gnt", bus.l_gnt, 0);
      step();
      bus.f_req = 1'b0;
      bus.l_req = 1'b0;

      // Randomized traffic; requesters hold their request until granted.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         fh = bus.f_req && bus.f_gnt;
         lh = bus.l_req && bus.l_gnt;
         step();
         if (!bus.f_req || fh) begin
            bus.f_req = ($urandom_range(0, 3) != 0);
            bus.f_adr = rand_adr();
         end
         if (!bus.l_req || lh) begin
            bus.l_req   = 1'($urandom_range(0, 1));
            bus.l_we    = 1'($urandom_range(0, 1));
            bus.l_adr   = rand_adr();
            bus.l_wdata = $urandom();
         end
         if ($urandom_range(0, 15) == 0) bus.l_lock = !bus.l_lock;
         bus.mem_done = ($urandom_range(0, 4) != 0);
      end

      bus.f_req    = 1'b0;
      bus.l_req    = 1'b0;
      bus.mem_done = 1'b1;
      step();
      step();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter that shares the single-ported instruction memory between the fetch stage (read-only) and the program loader / debug port (read-write). Requests are granted one per cycle while the memory reports `done`, and reads return with fixed one-cycle latency, tagged to the winning port. Arbitration is round-robin, with a bounded loader burst lock for boot-time image loads. An address range check blocks out-of-range writes from reaching the memory array.

## Interface
- `MEM_SIZE`, 1024: memory depth in 32-bit words; must match the memory instance.
- `MAX_BURST`, 8: maximum consecutive locked loader grants while fetch is waiting; range 1..255.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `f_req`  in  1  fetch request.
- `f_adr`  in  32  fetch byte address.
- `f_gnt`  out  1  fetch request accepted this cycle (combinational).
- `f_rvalid`  out  1  fetch read data valid.
- `f_rdata`  out  32  fetch read data.
- `f_err`  out  1  qualifies `f_rvalid`: address out of range.
- `l_req`  in  1  loader request.
- `l_we`  in  1  loader write (1) / read (0).
- `l_lock`  in  1  loader requests burst priority.
- `l_adr`  in  32  loader byte address.
- `l_wdata`  in  32  loader write data.
- `l_gnt`  out  1  loader request accepted this cycle (combinational).
- `l_rvalid`  out  1  loader response valid (read data or write ack).
- `l_rdata`  out  32  loader read data; 0 for writes.
- `l_err`  out  1  qualifies `l_rvalid`: address out of range.
- `mem_adr`  out  32  memory byte address.
- `mem_load`  out  1  memory write enable.
- `mem_in`  out  32  memory write data.
- `mem_out`  in  32  memory read data, registered inside memory.
- `mem_done`  in  1  memory ready to accept an access.

## Operation
- A handshake completes on a rising edge where `x_req && x_gnt`. A requester holds `req`, `adr`, `we`, and `wdata` stable until it is granted.
- Grants are only possible while `mem_done`=1. At most one of `f_gnt` / `l_gnt` is high in any cycle.
- Pick rule, evaluated in priority order:
  1. Only one port requesting: that port wins.
  2. Both requesting, `l_lock`=1, last winner = loader, and `burst_cnt` < `MAX_BURST`: loader wins.
  3. Otherwise: the port that did not win last wins.
- `last` register: reset value = loader, so fetch wins the first contention.
- `burst_cnt` (8-bit) behaviour:
  - Increments on each loader grant while `f_req`=1.
  - Clears on any fetch grant, or in any cycle where `l_lock`=0.
  - Saturates at `MAX_BURST`.
- Memory drive:
  - Idle cycles: `mem_adr`=0, `mem_load`=0, `mem_in`=0.
  - Granted cycle: `mem_adr`=winner address, `mem_load`=`l_we` (loader only), `mem_in`=`l_wdata`.
- Range check: an address is out of range when `adr[31:2]` ≥ `MEM_SIZE`. An out-of-range request is still granted, but `mem_load` is forced to 0 and the response carries `err`=1 with `rdata`=0.
- Address bits [1:0] are passed through unchanged; the memory ignores them.
- The response stage holds registered `owner` (none/fetch/loader), `is_wr`, and `oor` for the previous cycle's grant. It drives exactly one `x_rvalid` pulse:
  - Read: `x_rdata` = `mem_out`.
  - Write or `oor`: `x_rdata` = 0.
  - The non-owner port's `rvalid`/`rdata`/`err` are 0.

## Timing
- Grant is combinational in cycle N. The response appears in cycle N+1 (1-cycle latency). Back-to-back grants every cycle sustain full throughput.
- A write in cycle N followed by a read of the same address in cycle N+1 returns the new data in N+2.
- Reset values: `f_gnt`/`l_gnt`=0 (forced while `rst_n`=0), `f_rvalid`=`l_rvalid`=0, `*_rdata`=0, `*_err`=0, `mem_load`=0, `mem_adr`=0, `mem_in`=0, `owner`=none, `burst_cnt`=0, `last`=loader.
- Reset asserted mid-access: the pending response is dropped and no `rvalid` is issued after reset is released.
- `mem_done`=0 in cycle N: no grant in cycle N. Responses already in flight are unaffected.

## Structure
- Shared package `imem_pkg`:
  - `owner_t` enum: `OWN_NONE`, `OWN_FETCH`, `OWN_LOAD`.
  - Word-address width constant.
  - Default `MEM_SIZE`.
- Sub-module `imem_arb_pick`: combinational pick logic. Inputs: `f_req`, `l_req`, `l_lock`, `last`, `burst_cnt`, `mem_done`. Outputs: one-hot grant.
- Top level holds `last`, `burst_cnt`, the response stage, and the memory muxing.

## Test plan
- Fetch-only reads of 0x0, 0x4, 0x8 on consecutive cycles with a preloaded image -> `f_gnt`=1 each cycle; `f_rvalid` for words 0, 1, 2 in cycles +1, +2, +3.
- Both ports request reads continuously with `l_lock`=0 -> grants alternate F, L, F, L, starting with fetch after reset.
- `l_lock`=1 with loader writing 0x100..0x13C and `f_req` held high, `MAX_BURST`=8 -> 8 loader grants, 1 fetch grant, then 8 more loader grants.
- Loader writes 0xDEADBEEF to 0x40, then fetch reads 0x40 on the next cycle -> `l_rvalid` with `l_rdata`=0, then `f_rdata`=0xDEADBEEF.
- Loader write to 0x1000 (word 1024, `MEM_SIZE`=1024) -> `mem_load` stays 0; `l_rvalid`=1 with `l_err`=1; memory word 0 is unchanged.
- Assert `rst_n`=0 in the cycle after a fetch grant -> no `f_rvalid`; all outputs 0; the first contention after reset is won by fetch.
